conv1_pool_reader: RTL and testbench



---
 rtl/conv1_pkg.sv | 27 ++
 rtl/conv1_pool_lane.sv | 30 +++
 rtl/conv1_pool_reader.sv | 142 ++++++++++++++
 tb/tb_conv1_pool_reader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1_pkg.sv
// conv1 feature-map geometry, lane sizing and pool reader FSM states.
// Shared by conv1_pool_reader and conv1_pool_lane.
package conv1_pkg;

  localparam int C1_IMG_W  = 42;
  localparam int C1_IMG_H  = 61;
  localparam int C1_ADDR_W = 12;

  localparam int C1_NCH    = 4;
  localparam int C1_BYTE_W = 8;
  localparam int C1_WORD_W = C1_NCH * C1_BYTE_W;

  localparam int C1_POOL_W = C1_IMG_W / 2;
  localparam int C1_POOL_H = C1_IMG_H / 2;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    RD3,
    ACC,
    OUT,
    FIN
  } pool_state_t;

endpackage

// File: rtl/conv1_pool_lane.sv
// One channel's running max for 2x2 pooling.
// CONV1_POOL_SIGNED_EN selects a two's-complement compare.
module conv1_pool_lane
  import conv1_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 upd,
  input  logic [C1_BYTE_W-1:0] din,
  output logic [C1_BYTE_W-1:0] q
);

  logic gt;

`ifdef CONV1_POOL_SIGNED_EN
  assign gt = $signed(din) > $signed(q);
`else
  assign gt = din > q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load || (upd && gt)) begin
      q <= din;
    end
  end

endmodule

// File: rtl/conv1_pool_reader.sv
// Reads the conv1 map back and streams 2x2 stride-2 max-pooled words.
// CONV1_POOL_SIGNED_EN builds signed per-channel compare into the lanes.
module conv1_pool_reader
  import conv1_pkg::*;
#(
  parameter int IMG_W  = C1_IMG_W,
  parameter int IMG_H  = C1_IMG_H,
  parameter int ADDR_W = C1_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 enb,
  output logic [ADDR_W-1:0]    addrb,
  input  logic [C1_WORD_W-1:0] doutb,
  output logic [C1_WORD_W-1:0] pool_data,
  output logic                 pool_valid,
  input  logic                 pool_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int PH = IMG_H / 2;
  localparam int RW = $clog2(PH + 1);

  localparam logic [ADDR_W-1:0] W1    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] W2    = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] CLAST = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO   = ADDR_W'(2);

  pool_state_t st;

  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col_off;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] col_nx;
  logic [ADDR_W-1:0] nx_base;
  logic [RW-1:0]     row_idx;
  logic              col_wrap;
  logic              last_win;
  logic              lane_ld;
  logic              lane_up;

  assign base     = row_base + col_off;
  assign col_nx   = col_off + TWO;
  assign col_wrap = col_nx > CLAST;
  assign last_win = col_wrap && (row_idx == RW'(PH - 1));
  assign nx_base  = col_wrap ? (row_base + W2)
                             : (row_base + col_nx);

  // BRAM data lags the address by one cycle
  assign lane_ld = (st == RD1);
  assign lane_up = (st == RD2) || (st == RD3) || (st == ACC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      row_base   <= '0;
      col_off    <= '0;
      row_idx    <= '0;
      enb        <= 1'b0;
      addrb      <= '0;
      pool_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            st       <= RD0;
            row_base <= '0;
            col_off  <= '0;
            row_idx  <= '0;
            enb      <= 1'b1;
            addrb    <= '0;
            busy     <= 1'b1;
          end
        end
        RD0: begin
          addrb <= base + ONE;
          st    <= RD1;
        end
        RD1: begin
          addrb <= base + W1;
          st    <= RD2;
        end
        RD2: begin
          addrb <= base + W1 + ONE;
          st    <= RD3;
        end
        RD3: begin
          enb <= 1'b0;
          st  <= ACC;
        end
        ACC: begin
          pool_valid <= 1'b1;
          st         <= OUT;
        end
        OUT: begin
          if (pool_ready) begin
            pool_valid <= 1'b0;
            if (col_wrap) begin
              col_off  <= '0;
              row_base <= row_base + W2;
              row_idx  <= row_idx + RW'(1);
            end else begin
              col_off <= col_nx;
            end
            if (last_win) begin
              busy <= 1'b0;
              done <= 1'b1;
              st   <= FIN;
            end else begin
              enb   <= 1'b1;
              addrb <= nx_base;
              st    <= RD0;
            end
          end
        end
        FIN: begin
          done <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < C1_NCH; i++) begin : g_lane
    conv1_pool_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lane_ld),
      .upd   (lane_up),
      .din   (doutb[i*C1_BYTE_W +: C1_BYTE_W]),
      .q     (pool_data[i*C1_BYTE_W +: C1_BYTE_W])
    );
  end

endmodule

// File: tb/tb_conv1_pool_reader.sv
// Directed bench for conv1_pool_reader with a BRAM port-B model.
// Window vectors are table driven; scan, stall and abort are sequences.
`timescale 1ns/1ps
module tb_conv1_pool_reader;

  localparam int W  = 42;
  localparam int H  = 61;
  localparam int NW = W * H;
  localparam int PW = W / 2;
  localparam int PH = H / 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        enb;
  logic [11:0] addrb;
  logic [31:0] doutb = '0;
  logic [31:0] pool_data;
  logic        pool_valid;
  logic        pool_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [31:0] mem [NW];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv1_pool_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .enb        (enb),
    .addrb      (addrb),
    .doutb      (doutb),
    .pool_data  (pool_data),
    .pool_valid (pool_valid),
    .pool_ready (pool_ready),
    .busy       (busy),
    .done       (done)
  );

  always @(posedge clk) if (enb) doutb <= mem[addrb];

  // monitor: owns all recorded state; cleared on a mon_gen bump
  int          cyc = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          last_hs = -1;
  int          done_cyc = -1;
  logic        busy_at_done = 1'b1;
  logic [31:0] outs [$];
  int          addrs [$];
  int          mon_gen = 0;
  int          seen_gen = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_gen != seen_gen) begin
      seen_gen = mon_gen;
      outs.delete();
      addrs.delete();
      hs_cnt = 0;
      done_cnt = 0;
      last_hs = -1;
      done_cyc = -1;
      busy_at_done = 1'b1;
    end
    if (rst_n) begin
      if (enb) addrs.push_back(int'(addrb));
      if (pool_valid && pool_ready) begin
        outs.push_back(pool_data);
        hs_cnt++;
        last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic gt8(input logic [7:0] a, input logic [7:0] b);
`ifdef CONV1_POOL_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic int win_base(input int w);
    return (w / PW) * 2 * W + (w % PW) * 2;
  endfunction

  function automatic logic [31:0] ramp_exp(input int w);
    int          b;
    logic [7:0]  m;
    logic [7:0]  v;
    int          a [4];
    b = win_base(w);
    a[0] = b; a[1] = b + 1; a[2] = b + W; a[3] = b + W + 1;
    m = 8'(a[0]);
    for (int j = 1; j < 4; j++) begin
      v = 8'(a[j]);
      if (gt8(v, m)) m = v;
    end
    return {4{m}};
  endfunction

  task automatic fill_ramp();
    for (int a = 0; a < NW; a++) mem[a] = {4{8'(a)}};
  endtask

  task automatic mon_clear();
    @(posedge clk);
    #1 mon_gen++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!pool_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!pool_valid) chk("valid_timeout", 64'(pool_valid), 64'd1);
  endtask

  typedef struct {
    string       name;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] c, input logic [31:0] d,
      input logic [31:0] eu, input logic [31:0] es);
    vec_t v;
    v.name = nm; v.w0 = a; v.w1 = b; v.w2 = c; v.w3 = d;
`ifdef CONV1_POOL_SIGNED_EN
    v.exp = es;
`else
    v.exp = eu;
`endif
    return v;
  endfunction

  vec_t tv [8];

  initial begin
    int          n;
    int          bad;
    int          mx;
    int          k;
    logic [31:0] ex;

    tv[0] = mk("ramp_w0", 32'h0, 32'h01010101, 32'h2A2A2A2A,
               32'h2B2B2B2B, 32'h2B2B2B2B, 32'h2B2B2B2B);
    tv[1] = mk("ch0_ch3", 32'hFF000005, 32'h000000C8, 32'h00000007,
               32'h00000009, 32'hFF0000C8, 32'h00000009);
    tv[2] = mk("sign_edge", 32'h80808080, 32'h01010101, 32'hFFFFFFFF,
               32'h0, 32'hFFFFFFFF, 32'h01010101);
    tv[3] = mk("per_chan", 32'h10203040, 32'h40302010, 32'h01020304,
               32'h7F000001, 32'h7F303040, 32'h7F303040);
    tv[4] = mk("last_max", 32'h0, 32'h0, 32'h0,
               32'h01020304, 32'h01020304, 32'h01020304);
    tv[5] = mk("first_max", 32'h7E7E7E7E, 32'h11111111, 32'h22223333,
               32'h00000044, 32'h7E7E7E7E, 32'h7E7E7E7E);
    tv[6] = mk("all_high", 32'h81818181, 32'h90909090, 32'hFEFEFEFE,
               32'h80808080, 32'hFEFEFEFE, 32'hFEFEFEFE);
    tv[7] = mk("7f_vs_80", 32'h7F7F7F7F, 32'h80808080, 32'h0,
               32'h0, 32'h80808080, 32'h7F7F7F7F);

    fill_ramp();
    #1;
    chk("reset_outs", {enb, addrb, pool_data, pool_valid, busy, done}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single-window table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      mem[0] = tv[i].w0;
      mem[1] = tv[i].w1;
      mem[W] = tv[i].w2;
      mem[W + 1] = tv[i].w3;
      pool_ready = 1'b0;
      pulse_start();
      wait_valid(n);
      chk(tv[i].name, 64'(pool_data), 64'(tv[i].exp));
    end

    // full ramp scan, latency, spurious start, row wrap, done
    fill_ramp();
    do_reset();
    mon_clear();
    pool_ready = 1'b1;
    pulse_start();
    chk("rd0_first", {enb, addrb, busy}, {1'b1, 12'd0, 1'b1});
    wait_valid(n);
    chk("valid_latency", 64'(n), 64'd5);
    repeat (200) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("out_count", 64'(hs_cnt), 64'(PW * PH));
    chk("done_after_hs", 64'(done_cyc), 64'(last_hs + 1));
    chk("busy_low_at_done", 64'(busy_at_done), 64'd0);
    chk("idle_after", {enb, busy, pool_valid}, 3'b000);
    bad = 0;
    for (int w = 0; w < outs.size(); w++)
      if (outs[w] !== ramp_exp(w)) bad++;
    chk("ramp_data_errs", 64'(bad), 64'd0);
    chk("addr_count", 64'(addrs.size()), 64'(PW * PH * 4));
    bad = 0;
    mx = 0;
    for (int w = 0; w < PW * PH; w++) begin
      k = win_base(w);
      if (4 * w + 3 < addrs.size()) begin
        if (addrs[4*w] != k) bad++;
        if (addrs[4*w+1] != k + 1) bad++;
        if (addrs[4*w+2] != k + W) bad++;
        if (addrs[4*w+3] != k + W + 1) bad++;
      end
    end
    foreach (addrs[j]) if (addrs[j] > mx) mx = addrs[j];
    chk("addr_seq_errs", 64'(bad), 64'd0);
    chk("addr_max", 64'(mx), 64'd2519);
    if (addrs.size() >= 88) begin
      chk("w20_addrs", {16'(addrs[80]), 16'(addrs[81]), 16'(addrs[82]),
          16'(addrs[83])}, {16'd40, 16'd41, 16'd82, 16'd83});
      chk("w21_addrs", {16'(addrs[84]), 16'(addrs[85]), 16'(addrs[86]),
          16'(addrs[87])}, {16'd84, 16'd85, 16'd126, 16'd127});
    end else begin
      chk("wrap_addrs_len", 64'(addrs.size()), 64'd88);
    end

    // backpressure on the third window
    do_reset();
    pool_ready = 1'b0;
    pulse_start();
    for (int w = 0; w < 4; w++) begin
      wait_valid(n);
      chk("bp_data", 64'(pool_data), 64'(ramp_exp(w)));
      if (w == 2) begin
        ex = ramp_exp(2);
        for (int s = 0; s < 10; s++) begin
          chk("bp_stall", {pool_valid, enb, pool_data}, {1'b1, 1'b0, ex});
          @(negedge clk);
        end
      end
      pool_ready = 1'b1;
      @(negedge clk);
      pool_ready = 1'b0;
      chk("bp_next_rd0", {enb, addrb}, {1'b1, 12'(win_base(w + 1))});
    end

    // abort at window 100, then restart
    do_reset();
    mon_clear();
    pool_ready = 1'b1;
    pulse_start();
    n = 0;
    while (hs_cnt < 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_w100", 64'(hs_cnt >= 100), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {enb, addrb, pool_data, pool_valid, busy, done}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_idle", {enb, busy, pool_valid}, 3'b000);
    pulse_start();
    chk("restart_rd0", {enb, addrb, busy}, {1'b1, 12'd0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
